alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Registered, multi-cycle successor to the team's combinational N-bit ALU.
- Sits between an operand source and a result consumer, with valid/ready handshakes on both sides.
- Keeps the existing opcode map (ADD..SRA) and flag semantics.
- Adds:
  - a persistent carry flag used by ADC/SBC
  - rotates and compare
  - an iterative shift-add unsigned multiplier
  - an illegal-opcode error flag

Parameters:
- N, 8, operand/result width; N >= 2.
- MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL treated as illegal.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept an operation this cycle.
- A  in  N  operand A.
- B  in  N  operand B; shift/rotate amount is B[SHW-1:0], SHW = clog2(N).
- opcode  in  4  operation select.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result this cycle.
- Y  out  N  registered result.
- Z  out  1  Y == 0.
- C  out  1  carry flag (persistent; also ADC/SBC carry-in).
- Nf  out  1  Y[N-1].
- V  out  1  signed overflow.
- err  out  1  result came from an illegal opcode.
- busy  out  1  multiplier iterating.

Behaviour:
- Reset:
  - Y=0, Z=0, C=0, Nf=0, V=0, err=0.
  - out_valid=0, busy=0, state=IDLE, multiplier counter and accumulators cleared.
  - rst aborts any in-flight MUL; it overrides all handshakes in the same cycle.
- States:
  - IDLE: in_ready=1. Accept on in_valid. MUL goes to BUSY; anything else goes to DONE with the result registered at the accept edge.
  - BUSY: in_ready=0, busy=1. One shift-add step per cycle for N cycles, then DONE.
  - DONE: out_valid=1; Y and all flags held stable while !out_ready. in_ready = out_ready, so a new op is accepted on the same edge the result is consumed. With out_ready & !in_valid, go to IDLE.
- Latency (accept edge to out_valid high): 1 cycle for single-cycle ops; N+1 cycles for MUL. Throughput is 1 op/cycle for back-to-back single-cycle ops with out_ready held high.
- Operand capture: A, B, opcode and the current C are captured at the accept edge; later input changes are ignored.
- Flags: Z, Nf and V are computed from the final Y and registered with it. C is registered with the result and keeps its value until the next result.
- Opcodes, with carry flag Cf = C at the accept edge:
  - 0000 ADD: {C,Y} = A+B. V = ~(A^B)msb & (A^Y)msb.
  - 0001 SUB: {b,Y} = A-B. C = ~b (no-borrow). V = (A^B)msb & (A^Y)msb.
  - 0010 AND, 0011 OR, 0100 XOR, 0101 NOT(A): C=0, V=0.
  - 0110 SHL: Y = A<<sh. C = A[N-sh] if sh != 0, else 0.
  - 0111 SHR: Y = A>>sh. C = A[sh-1] if sh != 0, else 0.
  - 1000 SRA: arithmetic right shift. C = A[sh-1] if sh != 0, else 0. V=0.
  - 1001 ADC: {C,Y} = A+B+Cf. V as ADD.
  - 1010 SBC: {b,Y} = A-B-~Cf. C = ~b. V as SUB.
  - 1011 ROL, 1100 ROR: rotate by sh. C = last bit rotated out (ROL: Y[0]; ROR: Y[N-1]); sh=0 gives C=0.
  - 1101 MUL: unsigned A*B. Y = low N bits. C = V = (high N bits != 0).
  - 1110 CMP: flags exactly as SUB; Y = A (pass-through).
  - 1111, or 1101 with MUL_EN=0: Y=0, C=V=0, err=1. Takes the single-cycle path; Z=1 accordingly.
- err is 0 for every legal result.
- MUL datapath:
  - 2N-bit product accumulator with a shifted multiplicand.
  - Counter runs 0..N-1 and wraps back to 0 on completion.
  - in_valid is ignored while BUSY.

Test Plan:
- Reset during MUL (N=8: A=8'hFF, B=8'hFF, rst asserted 3 cycles after accept) -> next cycle out_valid=0, busy=0, in_ready=1, C=0; a following ADD 3+4 returns Y=7 after 1 cycle.
- ADD 8'hF0+8'h20 then ADC 8'h00+8'h00 back-to-back, out_ready=1 -> first result Y=8'h10 C=1 V=0; second Y=8'h01 C=0 Z=0; results on consecutive cycles.
- SUB 8'h80-8'h01 -> Y=8'h7F, C=1, V=1, Nf=0. Then CMP A=5, B=5 -> Y=5, Z=1, C=1, V=0.
- MUL A=8'h10, B=8'h11 -> out_valid exactly 9 cycles after accept, Y=8'h10, C=V=1, busy high for 8 cycles. MUL 3*5 -> Y=15, C=0.
- Backpressure: out_ready=0 for 4 cycles after SHL A=8'h81 sh=1 -> Y=8'h02, C=1 held stable, in_ready=0; releasing out_ready with a new in_valid accepts on that edge.
- Shift/rotate edges: ROR A=8'h01 sh=1 -> Y=8'h80, C=1, Nf=1; SRA 8'h80 sh=7 -> Y=8'hFF; any shift with sh=0 -> Y=A, C=0; opcode 4'hF -> Y=0, err=1, Z=1.

Source files
------------

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with valid/ready handshakes on both sides, a persistent
// carry flag, rotates, compare and an iterative shift-add unsigned multiplier.
module alu_seq #(
    parameter int N      = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   opcode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Y,
    output logic         Z,
    output logic         C,
    output logic         Nf,
    output logic         V,
    output logic         err,
    output logic         busy
);
    localparam int SHW  = $clog2(N);
    localparam int CNTW = $clog2(N);

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_XOR = 4'h4,
        OP_NOT = 4'h5,
        OP_SHL = 4'h6,
        OP_SHR = 4'h7,
        OP_SRA = 4'h8,
        OP_ADC = 4'h9,
        OP_SBC = 4'hA,
        OP_ROL = 4'hB,
        OP_ROR = 4'hC,
        OP_MUL = 4'hD,
        OP_CMP = 4'hE,
        OP_ILL = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state, state_n;
    op_e    op;
    logic   accept;
    logic   mul_op;
    logic   mul_last;

    // Multiplier scratch
    logic [2*N-1:0]  acc;
    logic [2*N-1:0]  mcand;
    logic [N-1:0]    mplr;
    logic [CNTW-1:0] cnt;
    logic [2*N-1:0]  step_acc;

    // Single-cycle datapath
    logic [SHW-1:0] sh;
    logic           add_cin;
    logic           sub_bin;
    logic [N:0]     sum;
    logic [N:0]     diff;
    logic           add_v;
    logic           sub_v;
    logic [N:0]     shl_ext;
    logic [N:0]     shr_ext;
    logic [N:0]     sra_ext;
    logic [N-1:0]   rol_y;
    logic [N-1:0]   ror_y;
    logic [N-1:0]   r_y;
    logic [N-1:0]   f_src;
    logic           r_c;
    logic           r_v;
    logic           r_z;
    logic           r_n;
    logic           r_err;

    assign op       = op_e'(opcode);
    assign mul_op   = MUL_EN && (op == OP_MUL);
    assign mul_last = (state == BUSY) && (cnt == CNTW'(N - 1));

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
            end
            BUSY: begin
                busy = 1'b1;
                if (mul_last) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                accept    = out_ready & in_valid;
                if (out_ready && !in_valid) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // A result being consumed and a new op being accepted share the same edge.
        if (accept) state_n = mul_op ? BUSY : DONE;
    end

    // ------------------------------------------------------- single-cycle ops
    assign sh      = B[SHW-1:0];
    assign add_cin = (op == OP_ADC) & C;
    assign sub_bin = (op == OP_SBC) & ~C;
    assign sum     = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, add_cin};
    assign diff    = {1'b0, A} - {1'b0, B} - {{N{1'b0}}, sub_bin};
    assign add_v   = ~(A[N-1] ^ B[N-1]) & (A[N-1] ^ sum[N-1]);
    assign sub_v   =  (A[N-1] ^ B[N-1]) & (A[N-1] ^ diff[N-1]);

    // One guard bit beside the operand catches the last bit shifted out.
    assign shl_ext = {1'b0, A} << sh;
    assign shr_ext = {A, 1'b0} >> sh;
    assign sra_ext = $signed({A, 1'b0}) >>> sh;
    // Three copies keep the rotate correct for any sh below 2N, so non-power-of-two N works.
    assign rol_y   = N'({A, A, A} << sh >> (2 * N));
    assign ror_y   = N'({A, A, A} >> sh);

    always_comb begin
        r_y   = '0;
        r_c   = 1'b0;
        r_v   = 1'b0;
        r_err = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                r_y = sum[N-1:0];
                r_c = sum[N];
                r_v = add_v;
            end
            OP_SUB, OP_SBC: begin
                r_y = diff[N-1:0];
                r_c = ~diff[N];
                r_v = sub_v;
            end
            OP_AND: r_y = A & B;
            OP_OR:  r_y = A | B;
            OP_XOR: r_y = A ^ B;
            OP_NOT: r_y = ~A;
            OP_SHL: begin
                r_y = shl_ext[N-1:0];
                r_c = shl_ext[N];
            end
            OP_SHR: begin
                r_y = shr_ext[N:1];
                r_c = shr_ext[0];
            end
            OP_SRA: begin
                r_y = sra_ext[N:1];
                r_c = sra_ext[0];
            end
            OP_ROL: begin
                r_y = rol_y;
                r_c = (sh != '0) & rol_y[0];
            end
            OP_ROR: begin
                r_y = ror_y;
                r_c = (sh != '0) & ror_y[N-1];
            end
            OP_CMP: begin
                r_y = A;
                r_c = ~diff[N];
                r_v = sub_v;
            end
            // Reached by OP_ILL, and by OP_MUL only when the multiplier is left out.
            default: r_err = 1'b1;
        endcase
    end

    // Compare reports the flags of the difference while passing A through.
    assign f_src = (op == OP_CMP) ? diff[N-1:0] : r_y;
    assign r_z   = (f_src == '0);
    assign r_n   = f_src[N-1];

    // ------------------------------------------------------------ multiplier
    assign step_acc = acc + (mplr[0] ? mcand : '0);

    always_ff @(posedge clk) begin
        // NOTE: synchronous reset clears every register, multiplier scratch included, so an aborted MUL leaves nothing behind.
        if (rst) begin
            Y     <= '0;
            Z     <= 1'b0;
            C     <= 1'b0;
            Nf    <= 1'b0;
            V     <= 1'b0;
            err   <= 1'b0;
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            cnt   <= '0;
        end else if (accept) begin
            if (mul_op) begin
                acc   <= '0;
                mcand <= {{N{1'b0}}, A};
                mplr  <= B;
                cnt   <= '0;
            end else begin
                Y   <= r_y;
                Z   <= r_z;
                C   <= r_c;
                Nf  <= r_n;
                V   <= r_v;
                err <= r_err;
            end
        end else if (state == BUSY) begin
            acc   <= step_acc;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            if (mul_last) begin
                cnt <= '0;
                Y   <= step_acc[N-1:0];
                Z   <= (step_acc[N-1:0] == '0);
                C   <= |step_acc[2*N-1:N];
                Nf  <= step_acc[N-1];
                V   <= |step_acc[2*N-1:N];
                err <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a driver pushes expected results at each accept,
// a separate monitor compares and pops whenever the DUT presents a result.
module tb_alu_seq;
    localparam int N    = 8;
    localparam int SHW  = $clog2(N);
    localparam int MASK = (1 << N) - 1;
    localparam int SMIN = -(1 << (N - 1));
    localparam int SMAX = (1 << (N - 1)) - 1;

    typedef struct {
        logic [N-1:0] y;
        bit           z;
        bit           c;
        bit           n;
        bit           v;
        bit           err;
        bit           mul;
        int           acc_edge;
    } exp_t;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [N-1:0] A         = '0;
    logic [N-1:0] B         = '0;
    logic [3:0]   opcode    = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] Y;
    logic         Z, C, Nf, V, err, busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   edges    = 0;
    exp_t sb[$];
    bit   model_c  = 1'b0;

    alu_seq #(.N(N), .MUL_EN(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .opcode   (opcode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Y        (Y),
        .Z        (Z),
        .C        (C),
        .Nf       (Nf),
        .V        (V),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [N-1:0] y, input bit z, input bit c, input bit n,
                                input bit v, input bit e, input bit mul);
        exp_t r;
        r.y = y; r.z = z; r.c = c; r.n = n; r.v = v; r.err = e; r.mul = mul; r.acc_edge = 0;
        return r;
    endfunction

    // Reference model: plain integer arithmetic straight from the opcode definitions.
    function automatic exp_t model(input logic [3:0] op, input logic [N-1:0] a,
                                   input logic [N-1:0] b, input bit cf);
        exp_t e;
        int   ua, ub, sa, sb_, sh, r, s, brw, fs;
        logic [N-1:0] bits;
        e  = mk('0, 0, 0, 0, 0, 0, 0);
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb_ = int'($signed(b));
        sh = int'(b[SHW-1:0]);
        fs = 0;
        case (op)
            4'h0, 4'h9: begin
                r = ua + ub + ((op == 4'h9) ? int'(cf) : 0);
                s = sa + sb_ + ((op == 4'h9) ? int'(cf) : 0);
                e.y = N'(r);
                e.c = (r > MASK);
                e.v = (s < SMIN) || (s > SMAX);
            end
            4'h1, 4'hA, 4'hE: begin
                brw = (op == 4'hA) ? int'(!cf) : 0;
                r = ua - ub - brw;
                s = sa - sb_ - brw;
                e.c = (r >= 0);
                e.v = (s < SMIN) || (s > SMAX);
                e.y = (op == 4'hE) ? a : N'(r);
                fs  = r;
            end
            4'h2: e.y = a & b;
            4'h3: e.y = a | b;
            4'h4: e.y = a ^ b;
            4'h5: e.y = ~a;
            4'h6: begin
                r = ua << sh;
                e.y = N'(r);
                e.c = r[N];
            end
            4'h7: begin
                e.y = N'(ua >> sh);
                e.c = (sh != 0) && ua[sh-1];
            end
            4'h8: begin
                e.y = N'(sa >>> sh);
                e.c = (sh != 0) && ua[sh-1];
            end
            4'hB: begin
                e.y = N'((ua << sh) | (ua >> (N - sh)));
                bits = e.y;
                e.c = (sh != 0) && bits[0];
            end
            4'hC: begin
                e.y = N'((ua >> sh) | (ua << (N - sh)));
                bits = e.y;
                e.c = (sh != 0) && bits[N-1];
            end
            4'hD: begin
                r = ua * ub;
                e.y = N'(r);
                e.c = (r > MASK);
                e.v = (r > MASK);
                e.mul = 1'b1;
            end
            default: begin
                e.y = '0;
                e.err = 1'b1;
            end
        endcase
        if (op != 4'hE) fs = int'(e.y);
        bits = N'(fs);
        e.z = (bits == '0);
        e.n = bits[N-1];
        return e;
    endfunction

    // Presents one op from a negedge until accepted, pushing its expectation on the accept.
    task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input int pct, input bit directed, input exp_t de, output int waited);
        exp_t e;
        bit   taken;
        taken  = 1'b0;
        waited = 0;
        opcode = op;
        A = a;
        B = b;
        in_valid = 1'b1;
        while (!taken && waited < 200) begin
            out_ready = ($urandom_range(0, 99) < pct);
            #1;
            if (in_ready) begin
                e = directed ? de : model(op, a, b, model_c);
                e.acc_edge = edges + 1;
                model_c = e.c;
                sb.push_back(e);
                taken = 1'b1;
            end else begin
                waited++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!taken) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: op %0h never accepted", op);
        end
    endtask

    task automatic idle(input int n, input int pct);
        in_valid = 1'b0;
        repeat (n) begin
            out_ready = ($urandom_range(0, 99) < pct);
            @(negedge clk);
        end
    endtask

    // Monitor
    initial begin
        bit   presented;
        int   busy_run;
        exp_t e;
        presented = 1'b0;
        busy_run  = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                presented = 1'b0;
                busy_run  = 0;
            end else begin
                check("in_ready", in_ready, out_valid ? out_ready : !busy);
                if (busy) busy_run++;
                if (out_valid) begin
                    check("result_expected", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e = sb[0];
                        if (!presented) begin
                            check("latency", edges - e.acc_edge + 1, e.mul ? N + 1 : 1);
                            if (e.mul) check("busy_cycles", busy_run, N);
                            busy_run  = 0;
                            presented = 1'b1;
                        end
                        check("Y", Y, e.y);
                        check("Z", Z, e.z);
                        check("C", C, e.c);
                        check("Nf", Nf, e.n);
                        check("V", V, e.v);
                        check("err", err, e.err);
                        if (out_ready) begin
                            void'(sb.pop_front());
                            presented = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Driver
    initial begin
        int   w;
        exp_t none;
        none = mk('0, 0, 0, 0, 0, 0, 0);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_Y", Y, 0);
        check("rst_Z", Z, 0);
        check("rst_C", C, 0);
        check("rst_Nf", Nf, 0);
        check("rst_V", V, 0);
        check("rst_err", err, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Reset lands three edges into a MUL.
        issue(4'hD, 8'hFF, 8'hFF, 100, 1'b0, none, w);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        sb.delete();
        model_c = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_C", C, 0);
        @(negedge clk);
        issue(4'h0, 8'h03, 8'h04, 100, 1'b1, mk(8'h07, 0, 0, 0, 0, 0, 0), w);

        // ADD then ADC back to back, carry chained through C.
        issue(4'h0, 8'hF0, 8'h20, 100, 1'b1, mk(8'h10, 0, 1, 0, 0, 0, 0), w);
        issue(4'h9, 8'h00, 8'h00, 100, 1'b1, mk(8'h01, 0, 0, 0, 0, 0, 0), w);
        check("adc_back_to_back", w, 0);

        issue(4'h1, 8'h80, 8'h01, 100, 1'b1, mk(8'h7F, 0, 1, 0, 1, 0, 0), w);
        issue(4'hE, 8'h05, 8'h05, 100, 1'b1, mk(8'h05, 1, 1, 0, 0, 0, 0), w);

        issue(4'hD, 8'h10, 8'h11, 100, 1'b1, mk(8'h10, 0, 1, 0, 1, 0, 1), w);
        issue(4'hD, 8'h03, 8'h05, 100, 1'b1, mk(8'h0F, 0, 0, 0, 0, 0, 1), w);

        // Backpressure on a SHL result, then release together with a new op.
        issue(4'h6, 8'h81, 8'h01, 100, 1'b1, mk(8'h02, 0, 1, 0, 0, 0, 0), w);
        in_valid = 1'b0;
        repeat (4) begin
            out_ready = 1'b0;
            #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_Y_hold", Y, 8'h02);
            check("bp_C_hold", C, 1);
            @(negedge clk);
        end
        issue(4'hC, 8'h01, 8'h01, 100, 1'b1, mk(8'h80, 0, 1, 1, 0, 0, 0), w);
        check("bp_release_accept", w, 0);

        issue(4'h8, 8'h80, 8'h07, 100, 1'b1, mk(8'hFF, 0, 0, 1, 0, 0, 0), w);
        issue(4'h6, 8'h5A, 8'h08, 100, 1'b1, mk(8'h5A, 0, 0, 0, 0, 0, 0), w);
        issue(4'h7, 8'hA5, 8'h10, 100, 1'b1, mk(8'hA5, 0, 0, 1, 0, 0, 0), w);
        issue(4'h8, 8'h81, 8'h00, 100, 1'b1, mk(8'h81, 0, 0, 1, 0, 0, 0), w);
        issue(4'hB, 8'hC3, 8'h00, 100, 1'b1, mk(8'hC3, 0, 0, 1, 0, 0, 0), w);
        issue(4'hC, 8'h3C, 8'hF8, 100, 1'b1, mk(8'h3C, 0, 0, 0, 0, 0, 0), w);
        issue(4'hF, 8'h12, 8'h34, 100, 1'b1, mk(8'h00, 1, 0, 0, 0, 1, 0), w);

        // Randomized ops with random backpressure and idle gaps.
        for (int i = 0; i < 300; i++) begin
            issue(4'($urandom_range(0, 15)), N'($urandom), N'($urandom), 70, 1'b0, none, w);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3), 50);
        end

        in_valid = 1'b0;
        for (int t = 0; t < 200 && sb.size() > 0; t++) begin
            out_ready = 1'b1;
            @(negedge clk);
        end
        check("drain_empty", sb.size(), 0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
